// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32I funct3 codes and access-size helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LDRESP, S_WR, S_ERR} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic is_byte(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0];
  endfunction
  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == F3_H[1:0];
  endfunction
  // the unused encodings 011/110/111 fall through to a full-word access
  function automatic logic is_word(input logic [2:0] f3);
    return !is_byte(f3) && !is_half(f3);
  endfunction
  function automatic logic is_unsigned(input logic [2:0] f3);
    return f3[2];
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return is_half(f3) ? a[0] : is_word(f3) ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/half lane extraction with sign/zero extension (loads) and lane merge into the old word (sub-word stores)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  assign b  = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign h  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign sx = !is_unsigned(funct3_i);
  assign ld_data_o = is_byte(funct3_i) ? {{24{sx & b[7]}}, b} :
                     is_half(funct3_i) ? {{16{sx & h[15]}}, h} : rdata_i;
  // overwrite only the addressed lane of the word just read back
  always_comb begin
    st_data_o = rdata_i;
    if (is_byte(funct3_i)) st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (is_half(funct3_i)) st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    else st_data_o = wdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores onto a word-addressed memory; LSU_MISALIGN_TRAP_EN enables the misalignment error path
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data
);
  lsu_state_e   state_q, state_d;
  logic         write_q;
  logic [2:0]   f3_q;
  logic [N-1:0] addr_q, wdata_q;
  logic [N-1:0] ld_data, st_data;
  logic         accept, mis;
  assign accept = req_valid && state_q == S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis      = misaligned(req_funct3, req_addr[1:0]);
  assign resp_err = state_q == S_ERR;
`else
  assign mis      = 1'b0;
  assign resp_err = 1'b0;
`endif
  // next state: full-word stores skip the read, sub-word stores read first to merge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !accept ? S_IDLE : mis ? S_ERR :
                         (req_write && is_word(req_funct3)) ? S_WR : S_RD;
      S_RD:    state_d = write_q ? S_WR : S_LDRESP;
      default: state_d = S_IDLE;
    endcase
  end
  // state register and request latch; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  lsu_align u_align (
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (mem_read_data),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );
  assign req_ready        = state_q == S_IDLE;
  assign resp_valid       = state_q == S_LDRESP || state_q == S_WR || state_q == S_ERR;
  assign resp_rdata       = state_q == S_LDRESP ? ld_data : '0;
  assign mem_addr         = {2'b00, addr_q[N-1:2]};
  assign mem_write_enable = state_q == S_WR;
  assign mem_write_data   = state_q == S_WR ? st_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, sub-word RMW stores, full-word stores, misalignment and reset abort
module tb_load_store_unit;
  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem [64];
  int          total = 0;
  int          passed = 0;
  int          fails = 0;
  load_store_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[5:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[5:0]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_rd_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_rd_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_rd_addr"}, mem_addr, {2'b00, a[31:2]});
    @(negedge clk);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_we"}, {31'b0, mem_write_enable}, 32'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_valid_off"}, {31'b0, resp_valid}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[1] <= 32'h12345678;
    mem[3] <= 32'h8899AABB;
    mem[8] <= 32'h11112222;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_load("lb_e", 3'b000, 32'h0E, 32'hFFFFFF99);
    do_load("lbu_e", 3'b100, 32'h0E, 32'h00000099);
    do_load("lb_d", 3'b000, 32'h0D, 32'hFFFFFFAA);
    do_load("lbu_c", 3'b100, 32'h0C, 32'h000000BB);
    do_load("lhu_e", 3'b101, 32'h0E, 32'h00008899);
    do_load("lh_c", 3'b001, 32'h0C, 32'hFFFFAABB);
    do_load("lw_c", 3'b010, 32'h0C, 32'h8899AABB);
    issue(1'b1, 3'b000, 32'h0E, 32'hFFFFFF55);
    chk("sb_rd_we", {31'b0, mem_write_enable}, 32'd0);
    chk("sb_rd_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("sb_wr_we", {31'b0, mem_write_enable}, 32'd1);
    chk("sb_wr_valid", {31'b0, resp_valid}, 32'd1);
    chk("sb_wr_data", mem_write_data, 32'h8855AABB);
    chk("sb_wr_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    chk("sb_mem", mem[3], 32'h8855AABB);
    chk("sb_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_we", {31'b0, mem_write_enable}, 32'd1);
    chk("sw_valid", {31'b0, resp_valid}, 32'd1);
    chk("sw_addr", mem_addr, 32'd4);
    chk("sw_data", mem_write_data, 32'hDEADBEEF);
    chk("sw_ready_busy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_ready", {31'b0, req_ready}, 32'd1);
    chk("sw_we_off", {31'b0, mem_write_enable}, 32'd0);
    do_load("lw_f3_111", 3'b111, 32'h10, 32'hDEADBEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h06, 32'h0);
    chk("mis_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'h0);
    chk("mis_we", {31'b0, mem_write_enable}, 32'd0);
    @(negedge clk);
    chk("mis_ready", {31'b0, req_ready}, 32'd1);
    chk("mis_err_off", {31'b0, resp_err}, 32'd0);
    issue(1'b1, 3'b001, 32'h21, 32'h0000ABCD);
    chk("mis_sh_we", {31'b0, mem_write_enable}, 32'd0);
    chk("mis_sh_err", {31'b0, resp_err}, 32'd1);
    @(negedge clk);
    chk("mis_sh_mem", mem[8], 32'h11112222);
`else
    do_load("lw_unal", 3'b010, 32'h06, 32'h12345678);
    chk("unal_err", {31'b0, resp_err}, 32'd0);
`endif
    issue(1'b1, 3'b001, 32'h22, 32'h0000BEEF);
    @(negedge clk);
    chk("abort_we_before", {31'b0, mem_write_enable}, 32'd1);
    chk("abort_data_before", mem_write_data, 32'hBEEF2222);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'b0, mem_write_enable}, 32'd0);
    chk("abort_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_wdata", mem_write_data, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_mem", mem[8], 32'h11112222);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 3'b001, 32'h22, 32'hCAFEBEEF);
    @(negedge clk);
    chk("sh_data", mem_write_data, 32'hBEEF2222);
    @(negedge clk);
    chk("sh_mem", mem[8], 32'hBEEF2222);
    do_load("lh_hi", 3'b001, 32'h22, 32'hFFFFBEEF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
